// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types for the round-robin bus arbiter: FSM state encoding and
// small width helpers used by the top level.
package bus_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width of the timeout counter; a disabled timeout still gets one bit so
    // the counter declaration never collapses to zero width.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Bus bundle between N requesters, the arbiter and one shared slave.
//
// Handshake: a requester raises req_valid[i] with stable req_addr/req_wdata
// slices and holds them until req_ready[i] pulses for one cycle; req_rdata
// and req_err[i] are valid in that same cycle. On the slave side slv_valid
// stays high with stable slv_addr/slv_wdata until the slave answers with
// slv_ready (which may be combinational from slv_valid); slv_rdata is taken
// in the cycle slv_ready is high.
//
// master: the surrounding environment (requesters plus the slave).
// slave : the arbiter itself.
interface bus_arbiter_rr_if #(
    parameter int N  = 4,
    parameter int AW = 4,
    parameter int DW = 4
);
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   req_rdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_err;
    logic            slv_valid;
    logic [AW-1:0]   slv_addr;
    logic [DW-1:0]   slv_wdata;
    logic [DW-1:0]   slv_rdata;
    logic            slv_ready;

    modport master (
        output req_valid, req_addr, req_wdata, slv_rdata, slv_ready,
        input  req_rdata, req_ready, req_err, slv_valid, slv_addr, slv_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, slv_rdata, slv_ready,
        output req_rdata, req_ready, req_err, slv_valid, slv_addr, slv_wdata
    );

endinterface

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the
// start pointer sits at bit 0, find the first set bit, then map the
// offset back to an absolute requester index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          any_req,
    output logic [IW-1:0] winner
);

    logic [N-1:0] rot;
    logic         found;
    int           off;
    int           sum;

    // Rotate, find-first, and wrap the index modulo N (N need not be a power of two).
    always_comb begin
        rot     = N'({req, req} >> start);
        any_req = |req;
        found   = 1'b0;
        off     = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = int'(start) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        winner = IW'(sum);
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one slave bus among N requesters with a
// single outstanding transaction. The winner's addr/wdata are latched,
// the slave is driven until it answers or the timeout fires, and the
// result goes back to the winner as a one-cycle ready (plus err on timeout).
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int AW      = 4,
    parameter int DW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_arbiter_rr_if.slave      bus,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output state_t               state_dbg
);

    localparam int            IW       = $clog2(N);
    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [N-1:0]  ONE_HOT0 = N'(1);

    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          sv_q, sv_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [N-1:0]  rdy_q, rdy_d;
    logic [N-1:0]  err_q, err_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] to_q, to_d;

    logic          any_req;
    logic [IW-1:0] win_id;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (bus.req_valid),
        .start   (rr_q),
        .any_req (any_req),
        .winner  (win_id)
    );

    // State and all output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sv_q    <= 1'b0;
            rdata_q <= '0;
            rdy_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sv_q    <= sv_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for slave or timeout in REQ,
    // advance the round-robin pointer in RESP.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sv_d    = sv_q;
        rdata_d = rdata_q;
        rdy_d   = '0;
        err_d   = '0;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = win_id;
                    addr_d  = bus.req_addr[int'(win_id) * AW +: AW];
                    wdata_d = bus.req_wdata[int'(win_id) * DW +: DW];
                    sv_d    = 1'b1;
                    to_d    = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A slave answer in the timeout cycle still completes normally.
                if (bus.slv_ready) begin
                    rdata_d = bus.slv_rdata;
                    rdy_d   = ONE_HOT0 << grant_q;
                    sv_d    = 1'b0;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (to_q == TO_LAST)) begin
                    rdata_d = '0;
                    rdy_d   = ONE_HOT0 << grant_q;
                    err_d   = ONE_HOT0 << grant_q;
                    sv_d    = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT != 0) begin
                    to_d = to_q + CW'(1);
                end
            end
            RESP: begin
                // No arbitration here: the winner drops valid while seeing ready.
                rr_d    = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
                state_d = IDLE;
            end
            default: begin
                sv_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.slv_valid = sv_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.req_rdata = rdata_q;
    assign bus.req_ready = rdy_q;
    assign bus.req_err   = err_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign state_dbg     = state_q;

endmodule
